// File: rtl/hdmi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_pkg
// Description : Shared definitions for the HDMI blanking-interval scheduler.
//               Contents:
//               - period output encoding
//               - packet-type indices
//               - period lengths
//               - scheduler state type
//               - a 4-bit popcount helper
// Revision    : 1.0 - initial release
// ============================================================================
package hdmi_pkg;

    // Period encoding driven on the scheduler's period output
    localparam logic [2:0] PER_CTRL         = 3'd0;
    localparam logic [2:0] PER_ISLAND_PRE   = 3'd1;
    localparam logic [2:0] PER_ISLAND_GUARD = 3'd2;
    localparam logic [2:0] PER_ISLAND_DATA  = 3'd3;
    localparam logic [2:0] PER_VIDEO_PRE    = 3'd4;
    localparam logic [2:0] PER_VIDEO_GUARD  = 3'd5;
    localparam logic [2:0] PER_VIDEO        = 3'd6;

    // Packet-type indices; index 3 doubles as the NULL packet selector
    localparam logic [1:0] PKT_ACR    = 2'd0;
    localparam logic [1:0] PKT_SAMPLE = 2'd1;
    localparam logic [1:0] PKT_AVI    = 2'd2;
    localparam logic [1:0] PKT_AINFO  = 2'd3;
    localparam logic [1:0] PKT_NULL   = 2'd3;

    // Period lengths in pixel clocks
    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PACKET_LEN   = 32;
    localparam int MIN_CTRL_LEN = 12;

    typedef enum logic [2:0] {
        ST_CTRL   = 3'd0,
        ST_IPRE   = 3'd1,
        ST_IGRD_L = 3'd2,
        ST_IDATA  = 3'd3,
        ST_IGRD_T = 3'd4,
        ST_VPRE   = 3'd5,
        ST_VGRD   = 3'd6
    } sched_state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 4; i++) begin
            s = s + {2'b00, v[i]};
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_slot_arbiter
// Description : Fixed-priority packet arbiter (ACR > sample > AVI > AInfo).
//               Keeps a per-island served mask, so a requester gets at most
//               one slot per island.
// Ports       : clk, rst_n  - pixel clock, async active-low reset
//               i_clear     - start of a new island: forget served requesters
//               i_take      - a slot is being filled with the current winner
//               i_req       - accepted request mask
//               o_valid     - some unserved request is available
//               o_sel       - winner index (NULL when none)
//               o_grant     - one-hot winner
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_slot_arbiter
    import hdmi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_take,
    input  logic [3:0] i_req,
    output logic       o_valid,
    output logic [1:0] o_sel,
    output logic [3:0] o_grant
);

    logic [3:0] r_served;
    logic [3:0] w_avail;

    assign w_avail = i_req & ~r_served;

    // Scan from the lowest priority upwards, so the lowest index wins last
    always_comb begin
        o_valid = 1'b0;
        o_sel   = PKT_NULL;
        o_grant = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            if (w_avail[i]) begin
                o_valid = 1'b1;
                o_sel   = 2'(i);
                o_grant = 4'b0001 << i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_served <= 4'b0000;
        end else if (i_clear) begin
            r_served <= 4'b0000;
        end else if (i_take && o_valid) begin
            r_served <= r_served | o_grant;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hdmi_island_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_island_scheduler
// Description : Splits each horizontal blank into three kinds of period:
//               - control
//               - data island, which carries the packets
//               - video preamble/guard
//               It also arbitrates four packet requesters into the island
//               slots. It runs in the pixel-clock domain.
// Ports       : clk, rst_n       - pixel clock, async active-low reset
//               i_de             - active-video enable
//               i_frame_end      - end-of-frame pulse (arms InfoFrames)
//               i_vid_next       - next line carries video
//               i_dvi            - DVI mode, no islands
//               i_req[3:0]       - ACR, sample, AVI, AInfo requests
//               o_grant[3:0]     - one-hot grant on the packet's first cycle
//               o_period[2:0]    - period type
//               o_packet_sel[1:0]- packet type of current slot (3 = NULL)
//               o_packet_start   - first cycle of each packet
//               o_packet_idx[4:0]- cycle within packet
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_island_scheduler
    import hdmi_pkg::*;
#(
    parameter int H_TOTAL      = 1650,
    parameter int H_ACTIVE     = 1280,
    parameter int ISLAND_START = 4,
    parameter int MAX_PACKETS  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_de,
    input  logic       i_frame_end,
    input  logic       i_vid_next,
    input  logic       i_dvi,
    input  logic [3:0] i_req,
    output logic [3:0] o_grant,
    output logic [2:0] o_period,
    output logic [1:0] o_packet_sel,
    output logic       o_packet_start,
    output logic [4:0] o_packet_idx
);

    localparam int H_BLANK = H_TOTAL - H_ACTIVE;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VLEAD   = PREAMBLE_LEN + GUARD_LEN;

    // The island plus a minimum control period must fit before the video
    // lead-in. Here that means S + 12 + 32n + 12 <= H_BLANK - 10.
    localparam int FIT_ROOM = H_BLANK - VLEAD - ISLAND_START - PREAMBLE_LEN
                              - 2 * GUARD_LEN - MIN_CTRL_LEN;
    localparam int FIT_N    = (FIT_ROOM < PACKET_LEN) ? 0 : FIT_ROOM / PACKET_LEN;
    localparam int N_LIMIT  = (FIT_N < MAX_PACKETS) ? FIT_N : MAX_PACKETS;

    localparam logic [4:0]    N_LIMIT_C = 5'(N_LIMIT);
    localparam logic [HW-1:0] HCNT_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] DECIDE_AT = HW'(ISLAND_START - 1);
    localparam logic [HW-1:0] VPRE_AT   = HW'(H_BLANK - VLEAD);
    localparam logic [4:0]    PRE_LAST  = 5'(PREAMBLE_LEN - 1);
    localparam logic [4:0]    GRD_LAST  = 5'(GUARD_LEN - 1);
    localparam logic [4:0]    PKT_LAST  = 5'(PACKET_LEN - 1);

    sched_state_t  r_state;
    logic          r_de_d;
    logic          r_sync;
    logic [HW-1:0] r_hcnt;
    logic [1:0]    r_pend;
    logic [4:0]    r_cnt;
    logic [4:0]    r_slot;
    logic [4:0]    r_n;

    logic          w_de_fall;
    logic [HW-1:0] w_hcnt;
    logic [3:0]    w_acc;
    logic [2:0]    w_req_cnt;
    logic [4:0]    w_n;
    logic          w_decide;
    logic          w_vid_start;
    logic          w_issue;
    logic          w_arb_valid;
    logic [1:0]    w_arb_sel;
    logic [3:0]    w_arb_grant;

    // Blank-relative position of the current cycle
    assign w_de_fall = r_de_d & ~i_de;
    assign w_hcnt    = w_de_fall               ? '0 :
                       (r_hcnt == HCNT_LAST)   ? '0 : r_hcnt + 1'b1;

    // InfoFrames are accepted only while armed for this frame; DVI masks all
    assign w_acc     = {i_req[3] & r_pend[1], i_req[2] & r_pend[0], i_req[1:0]}
                       & {4{~i_dvi}};
    assign w_req_cnt = popcount4(w_acc);
    assign w_n       = ({2'b00, w_req_cnt} > N_LIMIT_C) ? N_LIMIT_C
                                                        : {2'b00, w_req_cnt};

    // Nothing is scheduled until a de fall has aligned the counter
    assign w_decide    = r_sync && !i_de && !i_dvi && (w_hcnt == DECIDE_AT);
    assign w_vid_start = r_sync && i_vid_next && (w_hcnt == VPRE_AT);
    assign w_issue     = (r_state == ST_IDATA) && (r_cnt == 5'd0) && !i_de
                         && w_arb_valid;

    hdmi_slot_arbiter u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_decide),
        .i_take  (w_issue),
        .i_req   (w_acc),
        .o_valid (w_arb_valid),
        .o_sel   (w_arb_sel),
        .o_grant (w_arb_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_CTRL;
            r_de_d         <= 1'b0;
            r_sync         <= 1'b0;
            r_hcnt         <= '0;
            r_pend         <= 2'b00;
            r_cnt          <= 5'd0;
            r_slot         <= 5'd0;
            r_n            <= 5'd0;
            o_grant        <= 4'b0000;
            o_period       <= PER_CTRL;
            o_packet_sel   <= 2'd0;
            o_packet_start <= 1'b0;
            o_packet_idx   <= 5'd0;
        end else begin
            r_de_d <= i_de;
            r_hcnt <= w_hcnt;
            r_sync <= r_sync | w_de_fall;
            // frame_end wins over a same-cycle grant of that InfoFrame
            r_pend <= (r_pend & ~({2{w_issue}} & w_arb_grant[3:2]))
                      | {2{i_frame_end}};

            o_grant        <= 4'b0000;
            o_packet_start <= 1'b0;
            o_packet_idx   <= 5'd0;

            if (i_de) begin
                // Video overrides everything; a running island is abandoned
                o_period <= PER_VIDEO;
                r_state  <= ST_CTRL;
                r_cnt    <= 5'd0;
            end else begin
                case (r_state)
                    ST_CTRL: begin
                        o_period <= PER_CTRL;
                        r_cnt    <= 5'd0;
                        if (w_vid_start) begin
                            // This cycle is itself the first preamble cycle
                            o_period <= PER_VIDEO_PRE;
                            r_state  <= ST_VPRE;
                            r_cnt    <= 5'd1;
                        end else if (w_decide && (w_n != 5'd0)) begin
                            r_state <= ST_IPRE;
                            r_n     <= w_n;
                        end
                    end
                    ST_IPRE: begin
                        o_period <= PER_ISLAND_PRE;
                        r_cnt    <= r_cnt + 5'd1;
                        if (r_cnt == PRE_LAST) begin
                            r_state <= ST_IGRD_L;
                            r_cnt   <= 5'd0;
                        end
                    end
                    ST_IGRD_L: begin
                        o_period <= PER_ISLAND_GUARD;
                        r_cnt    <= r_cnt + 5'd1;
                        if (r_cnt == GRD_LAST) begin
                            r_state <= ST_IDATA;
                            r_cnt   <= 5'd0;
                            r_slot  <= 5'd0;
                        end
                    end
                    ST_IDATA: begin
                        o_period     <= PER_ISLAND_DATA;
                        o_packet_idx <= r_cnt;
                        r_cnt        <= r_cnt + 5'd1;
                        if (r_cnt == 5'd0) begin
                            // No winner means a withdrawn request: NULL slot
                            o_packet_start <= 1'b1;
                            o_packet_sel   <= w_arb_sel;
                            o_grant        <= w_issue ? w_arb_grant : 4'b0000;
                        end
                        if (r_cnt == PKT_LAST) begin
                            if (r_slot == r_n - 5'd1) begin
                                r_state <= ST_IGRD_T;
                            end else begin
                                r_slot <= r_slot + 5'd1;
                            end
                        end
                    end
                    ST_IGRD_T: begin
                        o_period <= PER_ISLAND_GUARD;
                        r_cnt    <= r_cnt + 5'd1;
                        if (r_cnt == GRD_LAST) begin
                            r_state <= ST_CTRL;
                            r_cnt   <= 5'd0;
                        end
                    end
                    ST_VPRE: begin
                        o_period <= PER_VIDEO_PRE;
                        r_cnt    <= r_cnt + 5'd1;
                        if (r_cnt == PRE_LAST) begin
                            r_state <= ST_VGRD;
                            r_cnt   <= 5'd0;
                        end
                    end
                    ST_VGRD: begin
                        o_period <= PER_VIDEO_GUARD;
                        r_cnt    <= r_cnt + 5'd1;
                        if (r_cnt == GRD_LAST) begin
                            r_state <= ST_CTRL;
                            r_cnt   <= 5'd0;
                        end
                    end
                    default: begin
                        o_period <= PER_CTRL;
                        r_state  <= ST_CTRL;
                        r_cnt    <= 5'd0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_island_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_island_scheduler
// Description : Directed self-checking bench for hdmi_island_scheduler.
//               - A 720p instance drives the main scenarios.
//               - A second instance with a 60-cycle blank shares the same
//                 inputs and must never open an island.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_island_scheduler;

    localparam int H_TOTAL  = 1650;
    localparam int H_ACTIVE = 1280;
    localparam int H_BLANK  = H_TOTAL - H_ACTIVE;

    localparam int P_CTRL  = 0;
    localparam int P_IPRE  = 1;
    localparam int P_IGRD  = 2;
    localparam int P_IDATA = 3;
    localparam int P_VPRE  = 4;
    localparam int P_VGRD  = 5;
    localparam int P_VIDEO = 6;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic       i_de        = 1'b0;
    logic       i_frame_end = 1'b0;
    logic       i_vid_next  = 1'b0;
    logic       i_dvi       = 1'b0;
    logic [3:0] i_req       = 4'b0000;

    logic [3:0] o_grant;
    logic [2:0] o_period;
    logic [1:0] o_packet_sel;
    logic       o_packet_start;
    logic [4:0] o_packet_idx;

    logic [3:0] s_grant;
    logic [2:0] s_period;
    logic [1:0] s_packet_sel;
    logic       s_packet_start;
    logic [4:0] s_packet_idx;

    int n_checks = 0;
    int n_errors = 0;

    // Per-line capture, indexed by blank-relative cycle
    logic [2:0] per_a  [H_TOTAL];
    logic [3:0] gr_a   [H_TOTAL];
    logic [1:0] sel_a  [H_TOTAL];
    logic       ps_a   [H_TOTAL];
    logic [4:0] idx_a  [H_TOTAL];
    logic [2:0] per_s  [H_TOTAL];
    int         grant_cnt, island_cnt, grant_cnt_s, island_cnt_s;

    always #5 clk = ~clk;

    hdmi_island_scheduler #(
        .H_TOTAL(1650), .H_ACTIVE(1280), .ISLAND_START(4), .MAX_PACKETS(2)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_de           (i_de),
        .i_frame_end    (i_frame_end),
        .i_vid_next     (i_vid_next),
        .i_dvi          (i_dvi),
        .i_req          (i_req),
        .o_grant        (o_grant),
        .o_period       (o_period),
        .o_packet_sel   (o_packet_sel),
        .o_packet_start (o_packet_start),
        .o_packet_idx   (o_packet_idx)
    );

    hdmi_island_scheduler #(
        .H_TOTAL(1340), .H_ACTIVE(1280), .ISLAND_START(4), .MAX_PACKETS(2)
    ) u_dut_short (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_de           (i_de),
        .i_frame_end    (i_frame_end),
        .i_vid_next     (i_vid_next),
        .i_dvi          (i_dvi),
        .i_req          (i_req),
        .o_grant        (s_grant),
        .o_period       (s_period),
        .o_packet_sel   (s_packet_sel),
        .o_packet_start (s_packet_start),
        .o_packet_idx   (s_packet_idx)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full line: H_BLANK cycles with de low, then active video.
    // A negative cycle argument disables that event.
    task automatic run_line(input logic [3:0] rq, input logic vn, input logic dv,
                            input int fe_k, input int wd_k, input logic [3:0] wd_mask,
                            input int rst_k);
        i_req        = rq;
        i_vid_next   = vn;
        i_dvi        = dv;
        grant_cnt    = 0;
        island_cnt   = 0;
        grant_cnt_s  = 0;
        island_cnt_s = 0;
        for (int k = 0; k < H_TOTAL; k++) begin
            i_de        = (k >= H_BLANK);
            i_frame_end = (k == fe_k);
            if (k == wd_k) i_req = i_req & wd_mask;
            if (k == rst_k) rst_n = 1'b0;
            if (rst_k >= 0 && k == rst_k + 2) rst_n = 1'b1;
            @(posedge clk);
            #1;
            per_a[k] = o_period;
            gr_a[k]  = o_grant;
            sel_a[k] = o_packet_sel;
            ps_a[k]  = o_packet_start;
            idx_a[k] = o_packet_idx;
            per_s[k] = s_period;
            if (o_grant != 4'b0000) grant_cnt++;
            if (o_period >= 3'd1 && o_period <= 3'd3) island_cnt++;
            if (s_grant != 4'b0000) grant_cnt_s++;
            if (s_period >= 3'd1 && s_period <= 3'd3) island_cnt_s++;
        end
        i_frame_end = 1'b0;
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst period", int'(o_period), P_CTRL);
        check("rst grant", int'(o_grant), 0);
        check("rst sel", int'(o_packet_sel), 0);
        check("rst start", int'(o_packet_start), 0);
        check("rst idx", int'(o_packet_idx), 0);
        rst_n = 1'b1;
        i_de  = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // A: ACR only, one-packet island plus video lead-in
        run_line(4'b0001, 1'b1, 1'b0, -1, -1, 4'hF, -1);
        check("A per3", int'(per_a[3]), P_CTRL);
        check("A per4", int'(per_a[4]), P_IPRE);
        check("A per11", int'(per_a[11]), P_IPRE);
        check("A per12", int'(per_a[12]), P_IGRD);
        check("A per13", int'(per_a[13]), P_IGRD);
        check("A per14", int'(per_a[14]), P_IDATA);
        check("A gr14", int'(gr_a[14]), 1);
        check("A ps14", int'(ps_a[14]), 1);
        check("A sel14", int'(sel_a[14]), 0);
        check("A idx45", int'(idx_a[45]), 31);
        check("A per45", int'(per_a[45]), P_IDATA);
        check("A per46", int'(per_a[46]), P_IGRD);
        check("A per47", int'(per_a[47]), P_IGRD);
        check("A per48", int'(per_a[48]), P_CTRL);
        check("A island len", island_cnt, 44);
        check("A per359", int'(per_a[359]), P_CTRL);
        check("A per360", int'(per_a[360]), P_VPRE);
        check("A per367", int'(per_a[367]), P_VPRE);
        check("A per368", int'(per_a[368]), P_VGRD);
        check("A per369", int'(per_a[369]), P_VGRD);
        check("A per370", int'(per_a[370]), P_VIDEO);

        // B: InfoFrames not yet armed, so only the sample request counts
        run_line(4'b1110, 1'b1, 1'b0, 1000, -1, 4'hF, -1);
        check("B gr14", int'(gr_a[14]), 2);
        check("B per46", int'(per_a[46]), P_IGRD);
        check("B grants", grant_cnt, 1);

        // C: armed, three accepted, capped at two slots
        run_line(4'b1110, 1'b1, 1'b0, -1, -1, 4'hF, -1);
        check("C gr14", int'(gr_a[14]), 2);
        check("C gr46", int'(gr_a[46]), 4);
        check("C sel46", int'(sel_a[46]), 2);
        check("C per77", int'(per_a[77]), P_IDATA);
        check("C idx77", int'(idx_a[77]), 31);
        check("C per78", int'(per_a[78]), P_IGRD);
        check("C per80", int'(per_a[80]), P_CTRL);
        check("short islands", island_cnt_s, 0);
        check("short grants", grant_cnt_s, 0);
        check("short per50", int'(per_s[50]), P_VPRE);

        // D: AVI already sent this frame
        run_line(4'b1110, 1'b1, 1'b0, -1, -1, 4'hF, -1);
        check("D gr14", int'(gr_a[14]), 2);
        check("D gr46", int'(gr_a[46]), 8);
        check("D sel46", int'(sel_a[46]), 3);

        // E: both InfoFrames consumed
        run_line(4'b1110, 1'b1, 1'b0, -1, -1, 4'hF, -1);
        check("E gr14", int'(gr_a[14]), 2);
        check("E per46", int'(per_a[46]), P_IGRD);
        check("E grants", grant_cnt, 1);

        // F: sample withdrawn after the decision, second slot goes NULL
        run_line(4'b0011, 1'b1, 1'b0, -1, 10, 4'b1101, -1);
        check("F gr14", int'(gr_a[14]), 1);
        check("F sel14", int'(sel_a[14]), 0);
        check("F gr46", int'(gr_a[46]), 0);
        check("F sel46", int'(sel_a[46]), 3);
        check("F ps46", int'(ps_a[46]), 1);
        check("F per46", int'(per_a[46]), P_IDATA);

        // G: DVI mode, everything requested, three lines
        for (int l = 0; l < 3; l++) begin
            run_line(4'b1111, 1'b1, 1'b1, (l == 0) ? 500 : -1, -1, 4'hF, -1);
            check($sformatf("G%0d grants", l), grant_cnt, 0);
            check($sformatf("G%0d islands", l), island_cnt, 0);
            check($sformatf("G%0d per360", l), int'(per_a[360]), P_VPRE);
            check($sformatf("G%0d per368", l), int'(per_a[368]), P_VGRD);
        end

        // H: reset in the middle of the island
        run_line(4'b0001, 1'b1, 1'b0, -1, -1, 4'hF, 20);
        check("H per19", int'(per_a[19]), P_IDATA);
        check("H per20", int'(per_a[20]), P_CTRL);
        check("H idx20", int'(idx_a[20]), 0);
        check("H gr20", int'(gr_a[20]), 0);
        check("H per21", int'(per_a[21]), P_CTRL);
        check("H per360", int'(per_a[360]), P_CTRL);
        check("H per370", int'(per_a[370]), P_VIDEO);

        // I: scheduling resumes after the next de fall
        run_line(4'b0001, 1'b1, 1'b0, -1, -1, 4'hF, -1);
        check("I per4", int'(per_a[4]), P_IPRE);
        check("I gr14", int'(gr_a[14]), 1);
        check("I per48", int'(per_a[48]), P_CTRL);
        check("I per360", int'(per_a[360]), P_VPRE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hdmi_island_scheduler.md
# hdmi_island_scheduler

- Sequences the horizontal blanking interval of each line into HDMI control, data-island and video-preamble periods.
- Arbitrates four packet requesters for the available packet slots: audio clock regeneration, audio sample, AVI InfoFrame and audio InfoFrame.
- Sits between the video timing outputs of `hdmi_interface` and the TERC4/packet encoder; runs in the pixel-clock domain.
- When `dvi` is high it emits only control and video periods.

## Interface
Parameters:
- `H_TOTAL`, 1650: pixel clocks per line.
- `H_ACTIVE`, 1280: active pixels per line.
- `ISLAND_START`, 4: blank-relative cycle at which an island preamble may begin.
- `MAX_PACKETS`, 2: packet slots per island (1..18).

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `de` in 1: active-video enable.
- `frame_end` in 1: one-cycle pulse at the end of each frame.
- `vid_next` in 1: next line carries active video; sampled at the video-preamble start.
- `dvi` in 1: DVI mode; suppresses islands.
- `req` in 4: packet requests, index 0 = ACR, 1 = audio sample, 2 = AVI, 3 = audio InfoFrame; level, held until granted.
- `grant` out 4: one-hot one-cycle pulse on the first cycle of the granted packet.
- `period` out 3: 0 CTRL, 1 ISLAND_PRE, 2 ISLAND_GUARD, 3 ISLAND_DATA, 4 VIDEO_PRE, 5 VIDEO_GUARD, 6 VIDEO.
- `packet_sel` out 2: packet type for the current slot; equals the requester index; 3 is also used as NULL when no requester is pending.
- `packet_start` out 1: pulse on the first of the 32 cycles of each packet.
- `packet_idx` out 5: cycle within the packet, 0..31.

## Operation
- `h_cnt` is a blank-relative counter; `H_BLANK = H_TOTAL - H_ACTIVE`.
  - It resets to 0 on the first cycle with `de` low after a cycle with `de` high.
  - Otherwise it increments and wraps from `H_TOTAL-1` to 0. Wrapping keeps vertical-blank lines cadenced.
- Frame pending flags:
  - `req[2]` and `req[3]` are accepted only while their pending flag is set. The flags are set by `frame_end` and cleared by the matching grant, giving one InfoFrame of each type per frame.
  - `req[0]` and `req[1]` are accepted whenever asserted.
- Decision at `h_cnt == ISLAND_START-1`, when `dvi` is low:
  - `n = min(popcount(accepted requests), MAX_PACKETS)`.
  - If `n == 0`, no island is opened this line.
- Island layout, starting at `S = ISLAND_START`:
  - 8 cycles ISLAND_PRE.
  - 2 cycles ISLAND_GUARD.
  - `n*32` cycles ISLAND_DATA.
  - 2 cycles ISLAND_GUARD.
  - Then CTRL.
- Fit limit: `n` is reduced so the island ends at least 12 cycles before `H_BLANK-10`.
  - Required: `S + 12 + 32n + 12 <= H_BLANK - 10`.
  - If even `n=1` does not fit, no island is opened.
- Slot arbitration, on each slot's first cycle:
  - Grant the lowest-index accepted request: fixed priority ACR > sample > AVI > AInfo.
  - Drive `packet_sel` to that index and pulse its `grant` bit.
  - A request granted in a slot is not granted again in the same island.
  - If none is pending (a request was withdrawn), the slot is NULL: `packet_sel = 3`, no grant.
- Video lead-in, if `vid_next` is high at `h_cnt == H_BLANK-10`:
  - VIDEO_PRE for `h_cnt` H_BLANK-10..H_BLANK-3.
  - VIDEO_GUARD for H_BLANK-2..H_BLANK-1.
- `period` = VIDEO whenever `de` is high, overriding all other periods.
- If `de` rises during an island (timing misconfiguration), the island is aborted immediately, with no grants after the abort.
- While `dvi` is high, no grants are issued; video preamble and guard are still produced.

## Timing
- All outputs are registered.
- Reset values: `period`=0, `grant`=0, `packet_sel`=0, `packet_start`=0, `packet_idx`=0, `h_cnt`=0, pending flags=0.
- `period` and `de` are cycle-aligned: an input change on cycle `t` appears on the outputs at `t+1`; the encoder delays video by one cycle to match.
- `grant` and `packet_start` are coincident. Requesters present packet data from the cycle after the grant.
- `frame_end` together with a grant to the same InfoFrame on the same cycle: the flag ends up set, because set wins.
- Reset asserted mid-island returns every output to its reset value asynchronously. The scheduler restarts at the next `de` fall.

## Structure
- Shared package `hdmi_pkg`:
  - Period encoding constants.
  - Packet-type indices.
  - Preamble length 8, guard length 2, packet length 32, minimum control period 12.
- One sub-module, `hdmi_slot_arbiter`: fixed-priority grant over the accepted-request mask, with a per-island served mask.

## Test plan
- 720p parameters, `req`=0001 held, `vid_next`=1 → island of exactly 44 cycles:
  - PRE at `h_cnt` 4..11.
  - GUARD at 12..13.
  - DATA at 14..45 with `grant[0]` at 14.
  - GUARD at 46..47.
  - VIDEO_PRE at 360..367, VIDEO_GUARD at 368..369.
- `frame_end`, then `req`=1110 with `MAX_PACKETS`=2:
  - Line 1 grants sample then AVI.
  - Line 2 grants sample then AInfo.
  - Line 3 grants sample only.
- `req[1]` withdrawn after the decision cycle, `n`=2 → the second slot is NULL, `packet_sel`=3, no grant.
- `dvi`=1 with all requests high for 3 lines → `grant` never asserts; VIDEO_PRE/VIDEO_GUARD are still present.
- `H_TOTAL`=1340 (H_BLANK=60), all requests high → no island (`n=1` needs 60 ≤ 50).
- `rst_n` low at `h_cnt`=20 mid-island → all outputs at reset values next cycle; the following line schedules normally.
